// File: rtl/bnn_layer_sched.sv
// ---------------------------------------------------------------------------
// bnn_layer_sched
//
// Sequencer for one binary fully-connected layer. It runs on the shared
// XNOR/accumulate datapath. The block accepts one input vector and latches
// it. It then walks the output tiles (LANES neurons each) one at a time:
//   - FETCH issues a weight-row read for the current tile.
//   - WAIT covers the datapath latency.
//   - At the end of WAIT the tile's LANES sums are captured into the
//     output buffer.
// When every tile has been captured, the whole result vector is presented
// downstream with a valid/ready handshake.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush_i       synchronous abort of the vector in flight
//   in_valid_i    input vector handshake; in_data_i carries the vector
//   in_ready_o
//   w_rd_en_o     weight-row read strobe; w_addr_o = tile index
//   w_addr_o      (the address holds its value between strobes)
//   dp_in_o       latched input vector fed to the datapath
//   dp_result_i   LANES sums for the tile currently in flight
//   out_valid_o   result vector handshake
//   out_ready_i
//   out_data_o    result vector; tile t occupies slice t
//   busy_o        high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module bnn_layer_sched #(
  parameter int INPUT_DIM  = 16,
  parameter int OUTPUT_DIM = 8,
  parameter int LANES      = 2,
  parameter int BIT_WIDTH  = 8,
  parameter int DP_LAT     = 2,
  localparam int NTILES    = OUTPUT_DIM / LANES,
  localparam int AW        = (NTILES > 1) ? $clog2(NTILES) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [INPUT_DIM*BIT_WIDTH-1:0]  in_data_i,
  output logic                            w_rd_en_o,
  output logic [AW-1:0]                   w_addr_o,
  output logic [INPUT_DIM*BIT_WIDTH-1:0]  dp_in_o,
  input  logic [LANES*BIT_WIDTH-1:0]      dp_result_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [OUTPUT_DIM*BIT_WIDTH-1:0] out_data_o,
  output logic                            busy_o
);

  localparam int IW = INPUT_DIM * BIT_WIDTH;
  localparam int OW = OUTPUT_DIM * BIT_WIDTH;
  localparam int LW = LANES * BIT_WIDTH;
  // The wait counter must be able to hold DP_LAT.
  localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT + 1) : 1;

  // Configuration guards, evaluated at elaboration.
  generate
    if ((OUTPUT_DIM % LANES) != 0) begin : g_bad_tiling
      $error("bnn_layer_sched: OUTPUT_DIM must be a multiple of LANES");
    end
    if (DP_LAT < 1) begin : g_bad_latency
      $error("bnn_layer_sched: DP_LAT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [AW-1:0] tile_r;
  logic [AW-1:0] tile_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          accept_s;
  logic          capture_s;
  logic          last_tile_s;

  logic          in_ready_r;
  logic          busy_r;
  logic          out_valid_r;
  logic          w_rd_en_r;
  logic [AW-1:0] w_addr_r;
  logic [IW-1:0] in_latch_r;
  logic [OW-1:0] out_buf_r;

  assign last_tile_s = (tile_r == AW'(NTILES - 1));

  // Next-state logic. Flush overrides every transition, including an accept in IDLE.
  always_comb begin
    state_next_s = state_r;
    tile_next_s  = tile_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    if (flush_i) begin
      state_next_s = ST_IDLE;
      tile_next_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_i) begin
            accept_s     = 1'b1;
            tile_next_s  = '0;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          // The weight row arrives next cycle. The sums follow DP_LAT cycles
          // after that, which is the cycle in which the counter reaches zero.
          cnt_next_s   = CW'(DP_LAT);
          state_next_s = ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            capture_s = 1'b1;
            if (last_tile_s) begin
              state_next_s = ST_DONE;
            end else begin
              tile_next_s  = tile_r + AW'(1);
              state_next_s = ST_FETCH;
            end
          end else begin
            cnt_next_s = cnt_r - CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DONE;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          tile_next_s  = '0;
        end
      endcase
    end
  end

  // State register, tile index and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      tile_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      tile_r  <= tile_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Handshake and status outputs, registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      w_rd_en_r   <= 1'b0;
      w_addr_r    <= '0;
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      w_rd_en_r   <= (state_next_s == ST_FETCH);
      // The address only moves with a strobe and otherwise holds its last row.
      if (state_next_s == ST_FETCH) begin
        w_addr_r <= tile_next_s;
      end
    end
  end

  // Input vector latch. It is written only on accept, so the datapath sees a stable operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_latch_r <= '0;
    end else if (accept_s) begin
      in_latch_r <= in_data_i;
    end
  end

  // Result buffer. One slice is captured per tile. A flush keeps the contents
  // and suppresses the capture that was pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_buf_r <= '0;
    end else if (capture_s) begin
      out_buf_r[tile_r*LW +: LW] <= dp_result_i;
    end
  end

  assign in_ready_o  = in_ready_r;
  assign busy_o      = busy_r;
  assign out_valid_o = out_valid_r;
  assign w_rd_en_o   = w_rd_en_r;
  assign w_addr_o    = w_addr_r;
  assign dp_in_o     = in_latch_r;
  assign out_data_o  = out_buf_r;

endmodule
